// File: rtl/alu_host_sequencer.sv
// Bus-master sequencer for the ALU operation protocol: launches one request,
// feeds operands onto INBUS, collects OUTBUS pushes and returns a response.
//
// Handshakes: a transfer happens on the rising edge where valid && ready are
// both high. Once resp_valid is raised, the response fields do not change
// until that transfer.
module alu_host_sequencer #(
  parameter int TIMEOUT      = 128,
  parameter int ABORT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset_input,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_q,
  input  logic [7:0] req_m,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [1:0] resp_op,
  output logic [7:0] resp_a,
  output logic [7:0] resp_q,
  output logic       resp_err,
  output logic       BEGIN,
  output logic [1:0] op_code,
  input  logic       loadA_in,
  input  logic       loadQ_in,
  input  logic       loadM_in,
  input  logic       pushA_in,
  input  logic       pushQ_in,
  input  logic       END,
  output logic [7:0] INBUS,
  input  logic [7:0] OUTBUS,
  output logic       alu_reset,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DONE, S_ABORT} state_t;

  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam int AB_W = $clog2(ABORT_CYCLES) + 1;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      a_q, a_d, q_q, q_d, m_q, m_d;
  logic [7:0]      res_a_q, res_a_d, res_q_q, res_q_d;
  logic            pend_a_q, pend_a_d, pend_q_q, pend_q_d;
  logic            seen_a_q, seen_a_d, seen_q_q, seen_q_d;
  logic            err_q, err_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [AB_W-1:0] ab_q, ab_d;

  logic multi_load, a_bad, q_bad, missing;

  assign multi_load = (loadA_in & loadQ_in) | (loadA_in & loadM_in) | (loadQ_in & loadM_in);

  // add/sub want only A; mul wants A then Q; div wants Q then A.
  always_comb begin
    case (op_q)
      2'b10:   begin a_bad = seen_q_q;  q_bad = ~seen_a_q; end
      2'b11:   begin a_bad = ~seen_q_q; q_bad = seen_a_q;  end
      default: begin a_bad = 1'b0;      q_bad = 1'b1;      end
    endcase
  end

  assign missing = ~seen_a_q | (op_q[1] & ~seen_q_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    q_d      = q_q;
    m_d      = m_q;
    res_a_d  = res_a_q;
    res_q_d  = res_q_q;
    pend_a_d = 1'b0;
    pend_q_d = 1'b0;
    seen_a_d = seen_a_q;
    seen_q_d = seen_q_q;
    err_d    = err_q;
    wd_d     = wd_q;
    ab_d     = ab_q;

    // A push registered in the last RUN cycle still lands while aborting.
    if (state_q == S_RUN || state_q == S_ABORT) begin
      if (pend_a_q) begin
        res_a_d  = OUTBUS;
        seen_a_d = 1'b1;
        if (a_bad) err_d = 1'b1;
      end
      if (pend_q_q) begin
        res_q_d  = OUTBUS;
        seen_q_d = 1'b1;
        if (q_bad) err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          a_d      = req_a;
          q_d      = req_q;
          m_d      = req_m;
          res_a_d  = 8'h00;
          res_q_d  = 8'h00;
          seen_a_d = 1'b0;
          seen_q_d = 1'b0;
          err_d    = 1'b0;
          state_d  = S_START;
        end
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        pend_a_d = pushA_in;
        pend_q_d = pushQ_in;
        if (multi_load) err_d = 1'b1;
        if (END) begin
          state_d = S_DONE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          ab_d    = '0;
          state_d = S_ABORT;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_ABORT: begin
        err_d = 1'b1;
        if (ab_q == AB_W'(ABORT_CYCLES - 1)) state_d = S_DONE;
        else                                 ab_d    = ab_q + AB_W'(1);
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_input) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      a_q      <= 8'h00;
      q_q      <= 8'h00;
      m_q      <= 8'h00;
      res_a_q  <= 8'h00;
      res_q_q  <= 8'h00;
      pend_a_q <= 1'b0;
      pend_q_q <= 1'b0;
      seen_a_q <= 1'b0;
      seen_q_q <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= '0;
      ab_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      q_q      <= q_d;
      m_q      <= m_d;
      res_a_q  <= res_a_d;
      res_q_q  <= res_q_d;
      pend_a_q <= pend_a_d;
      pend_q_q <= pend_q_d;
      seen_a_q <= seen_a_d;
      seen_q_q <= seen_q_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      ab_q     <= ab_d;
    end
  end

  always_comb begin
    INBUS = 8'h00;
    if (state_q == S_RUN) begin
      if (loadA_in)      INBUS = a_q;
      else if (loadQ_in) INBUS = q_q;
      else if (loadM_in) INBUS = m_q;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign BEGIN       = (state_q == S_START);
  assign resp_valid  = (state_q == S_DONE);
  assign alu_reset   = (state_q == S_ABORT);
  assign resp_err    = (state_q == S_DONE) & (err_q | missing);
  assign resp_op     = op_q;
  assign op_code     = op_q;
  assign resp_a      = res_a_q;
  assign resp_q      = res_q_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_host_sequencer.sv
// Directed bench for alu_host_sequencer: vector table of full operations plus
// hand-written timeout, backpressure and mid-run reset sequences.
module tb_alu_host_sequencer;

  localparam logic [1:0] P_N = 2'd0, P_A = 2'd1, P_Q = 2'd2;

  logic       clk = 1'b0;
  logic       reset_input, req_valid, req_ready;
  logic [1:0] req_op;
  logic [7:0] req_a, req_q, req_m;
  logic       resp_valid, resp_ready;
  logic [1:0] resp_op;
  logic [7:0] resp_a, resp_q;
  logic       resp_err, BEGIN;
  logic [1:0] op_code;
  logic       loadA_in, loadQ_in, loadM_in, pushA_in, pushQ_in, END;
  logic [7:0] INBUS, OUTBUS;
  logic       alu_reset;
  logic [2:0] dbg_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a, q, m;
    logic [1:0] p1;
    logic [7:0] v1;
    logic [1:0] p2;
    logic [7:0] v2;
    logic       dual;
    logic [7:0] ea, eq;
    logic       ee;
  } vec_t;

  vec_t vecs[8];

  alu_host_sequencer dut (
    .clk(clk), .reset_input(reset_input),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_q(req_q), .req_m(req_m),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
    .resp_a(resp_a), .resp_q(resp_q), .resp_err(resp_err),
    .BEGIN(BEGIN), .op_code(op_code),
    .loadA_in(loadA_in), .loadQ_in(loadQ_in), .loadM_in(loadM_in),
    .pushA_in(pushA_in), .pushQ_in(pushQ_in), .END(END),
    .INBUS(INBUS), .OUTBUS(OUTBUS), .alu_reset(alu_reset),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
  endtask

  // Driver tasks: each starts and ends just after a falling edge.
  task automatic do_req(input logic [1:0] op, input logic [7:0] a, q, m);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_q = q; req_m = m;
    cycle();
    req_valid = 1'b0;
    check("begin_pulse", BEGIN, 1);
    check("op_code", op_code, op);
    cycle();
    check("begin_low_in_run", BEGIN, 0);
  endtask

  task automatic do_loads(input logic [7:0] a, q, m, input logic dual);
    loadA_in = 1'b1; #1 check("inbus_a", INBUS, a);
    cycle(); loadA_in = 1'b0; loadQ_in = 1'b1; #1 check("inbus_q", INBUS, q);
    cycle(); loadQ_in = 1'b0; loadM_in = 1'b1; #1 check("inbus_m", INBUS, m);
    cycle(); loadM_in = 1'b0;
    if (dual) begin
      loadA_in = 1'b1; loadM_in = 1'b1; #1 check("inbus_dual_prio", INBUS, a);
      cycle(); loadA_in = 1'b0; loadM_in = 1'b0;
    end
    #1 check("inbus_idle_run", INBUS, 8'h00);
  endtask

  // First push, then OUTBUS a cycle later; END rides with the last OUTBUS value.
  task automatic do_pushes(input logic [1:0] p1, input logic [7:0] v1,
                           input logic [1:0] p2, input logic [7:0] v2);
    pushA_in = p1[0]; pushQ_in = p1[1];
    cycle(); pushA_in = 1'b0; pushQ_in = 1'b0; OUTBUS = v1;
    if (p2 != P_N) begin
      pushA_in = p2[0]; pushQ_in = p2[1];
      cycle(); pushA_in = 1'b0; pushQ_in = 1'b0; OUTBUS = v2;
    end
    END = 1'b1;
    cycle(); END = 1'b0; OUTBUS = 8'h00;
  endtask

  task automatic check_resp(input logic [1:0] op, input logic [7:0] ea, eq,
                            input logic ee, input int hold);
    logic stable_ok;
    check("resp_valid", resp_valid, 1);
    check("resp_op", resp_op, op);
    check("resp_a", resp_a, ea);
    check("resp_q", resp_q, eq);
    check("resp_err", resp_err, ee);
    check("req_ready_busy", req_ready, 0);
    stable_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      cycle();
      if (resp_valid !== 1'b1 || resp_a !== ea || resp_q !== eq ||
          resp_err !== ee || resp_op !== op || req_ready !== 1'b0)
        stable_ok = 1'b0;
    end
    if (hold > 0) check("backpressure_stable", stable_ok, 1);
    resp_ready = 1'b1;
    cycle(); resp_ready = 1'b0;
    check("req_ready_after_hs", req_ready, 1);
    check("resp_valid_after_hs", resp_valid, 0);
  endtask

  task automatic run_vec(input vec_t v, input int hold);
    do_req(v.op, v.a, v.q, v.m);
    do_loads(v.a, v.q, v.m, v.dual);
    do_pushes(v.p1, v.v1, v.p2, v.v2);
    check_resp(v.op, v.ea, v.eq, v.ee, hold);
  endtask

  initial begin
    logic ok;
    reset_input = 1'b1; req_valid = 1'b0; req_op = 2'b00;
    req_a = 8'h00; req_q = 8'h00; req_m = 8'h00; resp_ready = 1'b0;
    loadA_in = 1'b0; loadQ_in = 1'b0; loadM_in = 1'b0;
    pushA_in = 1'b0; pushQ_in = 1'b0; END = 1'b0; OUTBUS = 8'h00;

    //            op     a      q      m      p1   v1     p2   v2     dual  ea     eq     ee
    vecs[0] = '{2'b00, 8'h05, 8'h00, 8'h03, P_A, 8'h08, P_N, 8'h00, 1'b0, 8'h08, 8'h00, 1'b0};
    vecs[1] = '{2'b10, 8'h00, 8'h07, 8'h06, P_A, 8'h00, P_Q, 8'h2A, 1'b0, 8'h00, 8'h2A, 1'b0};
    vecs[2] = '{2'b11, 8'h00, 8'h23, 8'h10, P_Q, 8'h11, P_A, 8'h02, 1'b0, 8'h02, 8'h11, 1'b0};
    vecs[3] = '{2'b11, 8'h00, 8'h23, 8'h10, P_A, 8'h02, P_Q, 8'h11, 1'b0, 8'h02, 8'h11, 1'b1};
    vecs[4] = '{2'b00, 8'h01, 8'h02, 8'h03, P_N, 8'h00, P_N, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[5] = '{2'b01, 8'h30, 8'h00, 8'h20, P_A, 8'h10, P_Q, 8'h20, 1'b0, 8'h10, 8'h20, 1'b1};
    vecs[6] = '{2'b10, 8'h00, 8'h09, 8'h05, P_Q, 8'h44, P_A, 8'h55, 1'b0, 8'h55, 8'h44, 1'b1};
    vecs[7] = '{2'b01, 8'hAA, 8'hBB, 8'hCC, P_A, 8'hFE, P_N, 8'h00, 1'b1, 8'hFE, 8'h00, 1'b1};

    repeat (2) cycle();
    reset_input = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_begin", BEGIN, 0);
    check("rst_alu_reset", alu_reset, 0);
    check("rst_inbus", INBUS, 8'h00);
    check("rst_resp_a", resp_a, 8'h00);
    check("rst_resp_q", resp_q, 8'h00);
    check("rst_resp_op", resp_op, 2'b00);
    check("rst_op_code", op_code, 2'b00);

    // Strobes and END outside RUN are ignored.
    cycle();
    loadA_in = 1'b1; END = 1'b1; #1 check("inbus_outside_run", INBUS, 8'h00);
    cycle(); loadA_in = 1'b0; END = 1'b0;
    check("end_outside_run", resp_valid, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 0);

    // Backpressure: ten cycles of resp_ready low.
    run_vec(vecs[0], 10);

    // Timeout: one A push early, never END.
    do_req(2'b10, 8'h00, 8'h03, 8'h04);
    ok = 1'b1;
    for (int i = 0; i < 128; i++) begin
      if (i == 0) pushA_in = 1'b1;
      if (i == 1) begin pushA_in = 1'b0; OUTBUS = 8'h77; end
      if (i == 2) OUTBUS = 8'h00;
      if (alu_reset !== 1'b0 || resp_valid !== 1'b0) ok = 1'b0;
      cycle();
    end
    check("no_abort_before_timeout", ok, 1);
    check("abort_cycle0", alu_reset, 1);
    cycle();
    check("abort_cycle1", alu_reset, 1);
    check("abort_no_resp", resp_valid, 0);
    cycle();
    check("abort_released", alu_reset, 0);
    check_resp(2'b10, 8'h77, 8'h00, 1'b1, 0);

    // Reset mid-run, then a stray END.
    do_req(2'b00, 8'h11, 8'h22, 8'h33);
    reset_input = 1'b1;
    cycle(); reset_input = 1'b0;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_begin", BEGIN, 0);
    check("midrst_alu_reset", alu_reset, 0);
    END = 1'b1;
    cycle(); END = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) ok = 1'b0;
      cycle();
    end
    check("midrst_stray_end", ok, 1);

    run_vec(vecs[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
